// File: rtl/muldiv_stall_sequencer_if.sv
// Handshake bundle between the EX stage and the mul/div stall sequencer.
// MULDIV_PERF_CNT_EN adds the stallCycles/mdOps performance counter outputs.
interface muldiv_stall_sequencer_if;
    logic        mdValidE;
    logic        mdIsDivE;
    logic        divZeroE;
    logic        abortE;
    logic        mdStart;
    logic        mdCancel;
    logic        mdBusy;
    logic        mdResultSelE;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        flushM;
`ifdef MULDIV_PERF_CNT_EN
    logic [31:0] stallCycles;
    logic [31:0] mdOps;
`endif

    modport master (
`ifdef MULDIV_PERF_CNT_EN
        input  stallCycles, mdOps,
`endif
        output mdValidE, mdIsDivE, divZeroE, abortE,
        input  mdStart, mdCancel, mdBusy, mdResultSelE,
        input  stallF, stallD, stallE, flushM
    );

    modport slave (
`ifdef MULDIV_PERF_CNT_EN
        output stallCycles, mdOps,
`endif
        input  mdValidE, mdIsDivE, divZeroE, abortE,
        output mdStart, mdCancel, mdBusy, mdResultSelE,
        output stallF, stallD, stallE, flushM
    );
endinterface

// File: rtl/muldiv_stall_sequencer.sv
// Starts the iterative mul/div unit from EX and stalls F/D/E (bubbling M) until the result is ready.
// Optional MULDIV_PERF_CNT_EN adds saturating stall-cycle and operation counters.
module muldiv_stall_sequencer #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    muldiv_stall_sequencer_if.slave  md
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [CNT_W-1:0] load;
    logic             start, cancel, resultSel, stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // The counter holds the remaining RUN cycles, so RUN lasts LAT-2 cycles and DONE
    // lands LAT-1 cycles after the start; a load of 0 skips RUN entirely.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        load      = '0;
        start     = 1'b0;
        cancel    = 1'b0;
        resultSel = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (md.mdValidE && !md.abortE) begin
                    start = 1'b1;
                    stall = 1'b1;
                    load  = md.mdIsDivE ? DIV_LOAD : MUL_LOAD;
                    if ((md.mdIsDivE && md.divZeroE) || load == '0) begin
                        stateNext = DONE;
                    end else begin
                        cntNext   = load;
                        stateNext = RUN;
                    end
                end
            end
            RUN: begin
                stall = 1'b1;
                if (md.abortE) begin
                    cancel    = 1'b1;
                    cntNext   = '0;
                    stateNext = IDLE;
                end else begin
                    if (cnt != '0) cntNext = cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) stateNext = DONE;
                end
            end
            DONE: begin
                resultSel = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even with mdValidE asserted.
    assign md.mdStart      = start & ~reset;
    assign md.mdCancel     = cancel & ~reset;
    assign md.mdBusy       = (state == RUN) & ~reset;
    assign md.mdResultSelE = resultSel & ~reset;
    assign md.stallF       = stall & ~reset;
    assign md.stallD       = stall & ~reset;
    assign md.stallE       = stall & ~reset;
    assign md.flushM       = stall & ~reset;

`ifdef MULDIV_PERF_CNT_EN
    logic [31:0] stallCycles, mdOps;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCycles <= '0;
            mdOps       <= '0;
        end else begin
            if (stall && stallCycles != '1) stallCycles <= stallCycles + 32'd1;
            if (start && mdOps != '1)       mdOps       <= mdOps + 32'd1;
        end
    end

    assign md.stallCycles = stallCycles;
    assign md.mdOps       = mdOps;
`endif

endmodule

// File: tb/tb_muldiv_stall_sequencer.sv
// Scoreboard bench for muldiv_stall_sequencer: per-cycle expected output vectors are queued
// as stimulus is driven and popped when the outputs are sampled on the falling edge.
module tb_muldiv_stall_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_stall_sequencer_if mdIf ();

    muldiv_stall_sequencer #(
        .MUL_LAT(4),
        .DIV_LAT(32),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .md(mdIf.slave)
    );

    int total = 0;
    int bad = 0;
    int expStall = 0;
    int expOps = 0;
    logic [7:0] sb[$];

    // {start, cancel, busy, resultSel, stallF, stallD, stallE, flushM}
    function automatic logic [7:0] ev(input logic s, input logic c, input logic b,
                                      input logic r, input logic st);
        return {s, c, b, r, st, st, st, st};
    endfunction

    function automatic logic [7:0] obs();
        return {mdIf.mdStart, mdIf.mdCancel, mdIf.mdBusy, mdIf.mdResultSelE,
                mdIf.stallF, mdIf.stallD, mdIf.stallE, mdIf.flushM};
    endfunction

    task automatic drive(input logic v, input logic d, input logic z, input logic a);
        mdIf.mdValidE = v;
        mdIf.mdIsDivE = d;
        mdIf.divZeroE = z;
        mdIf.abortE   = a;
    endtask

    task automatic push(input logic [7:0] e);
        sb.push_back(e);
        if (e[0]) expStall++;
        if (e[7]) expOps++;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expStall = 0;
        expOps = 0;
        push(8'h00);
        #2;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL reset_held: got %b want %b", obs(), e);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h00);
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL reset_release: got %b want %b", obs(), e);
        end
`ifdef MULDIV_PERF_CNT_EN
        total++;
        if (mdIf.stallCycles !== 32'd0 || mdIf.mdOps !== 32'd0) begin
            bad++;
            $display("FAIL perf_reset: got %0d/%0d want 0/0", mdIf.stallCycles, mdIf.mdOps);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        logic [7:0] e;
        for (int c = 0; c < 5; c++) begin
            drive(c < 4, 1'b0, 1'b0, 1'b0);
            if (c == 0)      push(ev(1, 0, 0, 0, 1));
            else if (c < 3)  push(ev(0, 0, 1, 0, 1));
            else if (c == 3) push(ev(0, 0, 0, 1, 0));
            else             push(8'h00);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL mul c%0d: got %b want %b", c, obs(), e);
            end
            @(posedge clk);
            #1;
        end
`ifdef MULDIV_PERF_CNT_EN
        total++;
        if (mdIf.stallCycles !== 32'(expStall) || mdIf.mdOps !== 32'(expOps)) begin
            bad++;
            $display("FAIL perf_mul: got %0d/%0d want %0d/%0d",
                     mdIf.stallCycles, mdIf.mdOps, expStall, expOps);
        end
`endif
    endtask

    task automatic test_div();
        logic [7:0] e;
        for (int c = 0; c < 33; c++) begin
            drive(c < 32, 1'b1, 1'b0, 1'b0);
            if (c == 0)       push(ev(1, 0, 0, 0, 1));
            else if (c < 31)  push(ev(0, 0, 1, 0, 1));
            else if (c == 31) push(ev(0, 0, 0, 1, 0));
            else              push(8'h00);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL div c%0d: got %b want %b", c, obs(), e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] e;
        for (int c = 0; c < 3; c++) begin
            drive(c < 2, 1'b1, 1'b1, 1'b0);
            if (c == 0)      push(ev(1, 0, 0, 0, 1));
            else if (c == 1) push(ev(0, 0, 0, 1, 0));
            else             push(8'h00);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL divzero c%0d: got %b want %b", c, obs(), e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_abort_run();
        logic [7:0] e;
        for (int c = 0; c < 14; c++) begin
            drive(c <= 10, 1'b1, 1'b0, c == 10);
            if (c == 0)       push(ev(1, 0, 0, 0, 1));
            else if (c < 10)  push(ev(0, 0, 1, 0, 1));
            else if (c == 10) push(ev(0, 1, 1, 0, 1));
            else              push(8'h00);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL abort_run c%0d: got %b want %b", c, obs(), e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Abort while IDLE must not start; abort while DONE must not suppress the result.
    task automatic test_abort_idle_done();
        logic [7:0] e;
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: begin drive(1, 0, 0, 1); push(8'h00);             end
                1: begin drive(0, 0, 0, 0); push(8'h00);             end
                2: begin drive(1, 0, 0, 0); push(ev(1, 0, 0, 0, 1)); end
                3, 4: begin drive(1, 0, 0, 0); push(ev(0, 0, 1, 0, 1)); end
                5: begin drive(1, 0, 0, 1); push(ev(0, 0, 0, 1, 0)); end
                default: begin drive(0, 0, 0, 0); push(8'h00);       end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL abort_idle_done c%0d: got %b want %b", c, obs(), e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        for (int c = 0; c < 9; c++) begin
            drive(c < 8, 1'b0, 1'b0, 1'b0);
            case (c)
                0, 4:    push(ev(1, 0, 0, 0, 1));
                3, 7:    push(ev(0, 0, 0, 1, 0));
                8:       push(8'h00);
                default: push(ev(0, 0, 1, 0, 1));
            endcase
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL back_to_back c%0d: got %b want %b", c, obs(), e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            push(c == 0 ? ev(1, 0, 0, 0, 1) : ev(0, 0, 1, 0, 1));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL async_reset c%0d: got %b want %b", c, obs(), e);
            end
            @(posedge clk);
            #1;
        end
        push(ev(0, 0, 1, 0, 1));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL async_reset c5_pre: got %b want %b", obs(), e);
        end
        reset = 1'b1;
        push(8'h00);
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL async_reset immediate: got %b want %b", obs(), e);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expStall = 0;
        expOps = 0;
        for (int c = 0; c < 3; c++) begin
            push(8'h00);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL async_reset idle%0d: got %b want %b", c, obs(), e);
            end
            @(posedge clk);
            #1;
        end
`ifdef MULDIV_PERF_CNT_EN
        total++;
        if (mdIf.stallCycles !== 32'd0 || mdIf.mdOps !== 32'd0) begin
            bad++;
            $display("FAIL perf_after_reset: got %0d/%0d want 0/0", mdIf.stallCycles, mdIf.mdOps);
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_abort_run();
        test_abort_idle_done();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
